// File: rtl/vec_twos_comp_pipe.sv
// Pipelined per-lane two's-complement unit (8/16/32-bit lanes) with a carry-select increment.
// Define VEC_TWOS_COMP_OVF_FLAG_EN to add the per-byte most-negative-value flag output ovf_flag.
module vec_twos_comp_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   operand,
  input  logic [1:0]              precision,
  input  logic [DATA_WIDTH/8-1:0] negate,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   result
`ifdef VEC_TWOS_COMP_OVF_FLAG_EN
  ,
  output logic [DATA_WIDTH/8-1:0] ovf_flag
`endif
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int NBLK = DATA_WIDTH / BLOCK_WIDTH;
  localparam int BPB  = 8 / BLOCK_WIDTH;

  function automatic int lane_bytes(input logic [1:0] prec);
    case (prec)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // Carry ripples block to block through all-ones blocks and restarts at every lane boundary.
  function automatic logic [DATA_WIDTH-1:0] resolve(
    input logic [DATA_WIDTH-1:0] s0,
    input logic [DATA_WIDTH-1:0] s1,
    input logic [NBLK-1:0]       p,
    input logic [NB-1:0]         nb,
    input logic [1:0]            prec
  );
    logic [DATA_WIDTH-1:0] r;
    logic                  c;
    int                    lb;
    r  = '0;
    c  = 1'b0;
    lb = lane_bytes(prec);
    for (int k = 0; k < NBLK; k++) begin
      if ((k % BPB) == 0 && ((k / BPB) % lb) == 0) c = nb[k / BPB];
      r[k*BLOCK_WIDTH +: BLOCK_WIDTH] = c ? s1[k*BLOCK_WIDTH +: BLOCK_WIDTH]
                                          : s0[k*BLOCK_WIDTH +: BLOCK_WIDTH];
      c = c & p[k];
    end
    return r;
  endfunction

  logic [NB-1:0]         n_byte_d;
  logic [DATA_WIDTH-1:0] xn_d;
  logic [DATA_WIDTH-1:0] sum1_d;
  logic [NBLK-1:0]       p_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] result_q;

  // Every byte inherits the negate flag of the top byte of its lane.
  always_comb begin
    int lb;
    lb       = lane_bytes(precision);
    n_byte_d = '0;
    for (int b = 0; b < NB; b++) n_byte_d[b] = negate[b | (lb - 1)];
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_byte
      assign xn_d[gi*8 +: 8] = operand[gi*8 +: 8] ^ {8{n_byte_d[gi]}};
    end
    for (gi = 0; gi < NBLK; gi++) begin : g_blk
      assign sum1_d[gi*BLOCK_WIDTH +: BLOCK_WIDTH] =
        xn_d[gi*BLOCK_WIDTH +: BLOCK_WIDTH] + BLOCK_WIDTH'(1);
      assign p_d[gi] = &xn_d[gi*BLOCK_WIDTH +: BLOCK_WIDTH];
    end
  endgenerate

`ifdef VEC_TWOS_COMP_OVF_FLAG_EN
  logic [NB-1:0] ovf_d;
  logic [NB-1:0] ovf_q;

  generate
    for (gi = 0; gi < NB; gi++) begin : g_ovf
      logic mn8;
      logic mn16;
      logic mn32;
      logic sel;
      assign mn8 = (operand[gi*8 +: 8] == 8'h80);
      if (gi % 2 == 1) begin : g_m16
        assign mn16 = mn8 & (operand[gi*8-1 -: 8] == 8'h00);
      end else begin : g_n16
        assign mn16 = 1'b0;
      end
      if (gi % 4 == 3) begin : g_m32
        assign mn32 = mn8 & (operand[gi*8-1 -: 24] == 24'h0);
      end else begin : g_n32
        assign mn32 = 1'b0;
      end
      always_comb begin
        case (precision)
          2'b00:   sel = mn8;
          2'b01:   sel = mn16;
          default: sel = mn32;
        endcase
      end
      assign ovf_d[gi] = negate[gi] & sel;
    end
  endgenerate

  assign ovf_flag = ovf_q;
`endif

  generate
    if (PIPE_STAGES == 2) begin : g_two
      logic                  s1_valid_q;
      logic [DATA_WIDTH-1:0] s0_q;
      logic [DATA_WIDTH-1:0] s1sum_q;
      logic [NBLK-1:0]       p_q;
      logic [NB-1:0]         nb_q;
      logic [1:0]            prec_q;
      logic                  advance;
      logic                  accept;
`ifdef VEC_TWOS_COMP_OVF_FLAG_EN
      logic [NB-1:0]         ovf1_q;
`endif

      assign advance  = s1_valid_q & (~out_valid_q | out_ready);
      assign in_ready = ~s1_valid_q | advance;
      assign accept   = in_valid & in_ready;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid_q  <= 1'b0;
          s0_q        <= '0;
          s1sum_q     <= '0;
          p_q         <= '0;
          nb_q        <= '0;
          prec_q      <= '0;
          out_valid_q <= 1'b0;
          result_q    <= '0;
`ifdef VEC_TWOS_COMP_OVF_FLAG_EN
          ovf1_q      <= '0;
          ovf_q       <= '0;
`endif
        end else begin
          if (accept) begin
            s1_valid_q <= 1'b1;
            s0_q       <= xn_d;
            s1sum_q    <= sum1_d;
            p_q        <= p_d;
            nb_q       <= n_byte_d;
            prec_q     <= precision;
`ifdef VEC_TWOS_COMP_OVF_FLAG_EN
            ovf1_q     <= ovf_d;
`endif
          end else if (advance) begin
            s1_valid_q <= 1'b0;
          end
          if (advance) begin
            out_valid_q <= 1'b1;
            result_q    <= resolve(s0_q, s1sum_q, p_q, nb_q, prec_q);
`ifdef VEC_TWOS_COMP_OVF_FLAG_EN
            ovf_q       <= ovf1_q;
`endif
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
      end
    end else if (PIPE_STAGES == 1) begin : g_one
      logic accept;

      assign in_ready = ~out_valid_q | out_ready;
      assign accept   = in_valid & in_ready;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          result_q    <= '0;
`ifdef VEC_TWOS_COMP_OVF_FLAG_EN
          ovf_q       <= '0;
`endif
        end else if (accept) begin
          out_valid_q <= 1'b1;
          result_q    <= resolve(xn_d, sum1_d, p_d, n_byte_d, precision);
`ifdef VEC_TWOS_COMP_OVF_FLAG_EN
          ovf_q       <= ovf_d;
`endif
        end else if (out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end else begin : g_bad
      $error("vec_twos_comp_pipe: PIPE_STAGES must be 1 or 2");
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_vec_twos_comp_pipe.sv
// Bench for vec_twos_comp_pipe: a 2-stage and a 1-stage instance share stimulus, each with its own scoreboard.
`timescale 1ns/1ps
module tb_vec_twos_comp_pipe;

  localparam int DW = 32;
  localparam int NB = DW / 8;
`ifdef VEC_TWOS_COMP_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] operand = '0;
  logic [1:0]    precision = '0;
  logic [NB-1:0] negate = '0;

  logic          in_ready2, out_valid2, in_ready1, out_valid1;
  logic [DW-1:0] result2, result1;
  logic [NB-1:0] ovf2, ovf1;

  always #5 clk = ~clk;

  vec_twos_comp_pipe #(.DATA_WIDTH(DW), .BLOCK_WIDTH(4), .PIPE_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .operand(operand), .precision(precision), .negate(negate),
    .out_valid(out_valid2), .out_ready(out_ready), .result(result2)
`ifdef VEC_TWOS_COMP_OVF_FLAG_EN
    , .ovf_flag(ovf2)
`endif
  );

  vec_twos_comp_pipe #(.DATA_WIDTH(DW), .BLOCK_WIDTH(4), .PIPE_STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .operand(operand), .precision(precision), .negate(negate),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1)
`ifdef VEC_TWOS_COMP_OVF_FLAG_EN
    , .ovf_flag(ovf1)
`endif
  );

`ifndef VEC_TWOS_COMP_OVF_FLAG_EN
  assign ovf2 = '0;
  assign ovf1 = '0;
`endif

  int checks = 0;
  int errors = 0;
  logic [NB+DW-1:0] q2[$];
  logic [NB+DW-1:0] q1[$];
  logic             acc2 = 1'b0, acc1 = 1'b0;
  logic             hold2 = 1'b0, hold1 = 1'b0;
  logic [DW-1:0]    hv2 = '0, hv1 = '0;

  // Lane-by-lane negation in plain arithmetic; returns {ovf, result}.
  function automatic logic [NB+DW-1:0] model(input logic [DW-1:0] op, input logic [1:0] prec,
                                             input logic [NB-1:0] neg);
    int            w, top;
    logic [31:0]   m, v, r;
    logic [DW-1:0] res;
    logic [NB-1:0] ovf;
    w   = (prec == 2'b00) ? 8 : (prec == 2'b01) ? 16 : 32;
    m   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    res = '0;
    ovf = '0;
    for (int l = 0; l < DW / w; l++) begin
      v   = 32'(op >> (l * w)) & m;
      top = (l + 1) * (w / 8) - 1;
      r   = neg[top] ? ((32'd0 - v) & m) : v;
      res = res | (DW'(r) << (l * w));
      if (OVF_EN && neg[top] && v == (32'd1 << (w - 1))) ovf[top] = 1'b1;
    end
    return {ovf, res};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, update scoreboards, then return 1ns after the rising edge.
  task automatic step();
    logic [NB+DW-1:0] e;
    @(negedge clk);
    if (hold2) begin
      chk("hold_valid2", out_valid2, 1);
      chk("hold_result2", result2, hv2);
    end
    if (hold1) begin
      chk("hold_valid1", out_valid1, 1);
      chk("hold_result1", result1, hv1);
    end
    hold2 = out_valid2 && !out_ready;
    hv2   = result2;
    hold1 = out_valid1 && !out_ready;
    hv1   = result1;
    if (out_valid2 && out_ready) begin
      if (q2.size() == 0) chk("spurious_out2", out_valid2, 0);
      else begin
        e = q2.pop_front();
        chk("result2", {ovf2, result2}, e);
      end
    end
    if (out_valid1 && out_ready) begin
      if (q1.size() == 0) chk("spurious_out1", out_valid1, 0);
      else begin
        e = q1.pop_front();
        chk("result1", {ovf1, result1}, e);
      end
    end
    acc2 = in_valid && in_ready2;
    acc1 = in_valid && in_ready1;
    if (acc2) q2.push_back(model(operand, precision, negate));
    if (acc1) q1.push_back(model(operand, precision, negate));
    $display("t=%0t in_v=%0b op=%h prec=%0d neg=%b | acc2=%0b ov2=%0b r2=%h | acc1=%0b ov1=%0b r1=%h",
             $time, in_valid, operand, precision, negate, acc2, out_valid2, result2,
             acc1, out_valid1, result1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] op, input logic [1:0] pr, input logic [NB-1:0] ng);
    operand   = op;
    precision = pr;
    negate    = ng;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc2) break;
    end
    if (!acc2) chk("accept_timeout", acc2, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB+DW-1:0] eg;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid2", out_valid2, 0);
    chk("rst_result2", result2, 0);
    chk("rst_out_valid1", out_valid1, 0);
    chk("rst_result1", result1, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready2", in_ready2, 1);
    chk("rst_in_ready1", in_ready1, 1);

    // Case 1: 8-bit lanes, full negate
    out_ready = 1'b1;
    send(32'h01FF_8000, 2'b00, 4'b1111);
    chk("c1_valid1_lat1", out_valid1, 1);
    chk("c1_result1", result1, 32'hFF01_8000);
    chk("c1_valid2_not_yet", out_valid2, 0);
    step();
    chk("c1_valid2_lat2", out_valid2, 1);
    chk("c1_result2", result2, 32'hFF01_8000);
    chk("c1_ovf2", ovf2, OVF_EN ? 4'b0010 : 4'b0000);
    step();

    // Case 2: 16-bit lanes, upper lane only
    send(32'h0001_0001, 2'b01, 4'b1000);
    step();
    chk("c2_result2", result2, 32'hFFFF_0001);
    step();

    // Case 3: 32-bit carry through every block
    send(32'h0000_0000, 2'b10, 4'b1000);
    chk("c3a_result1", result1, 32'h0000_0000);
    step();
    chk("c3a_result2", result2, 32'h0000_0000);
    send(32'h0000_0001, 2'b10, 4'b1000);
    chk("c3b_result1", result1, 32'hFFFF_FFFF);
    step();
    chk("c3b_result2", result2, 32'hFFFF_FFFF);
    step();

    // Case 4: backpressure with four back-to-back beats
    send(32'h1234_5678, 2'b00, 4'b0101);
    out_ready = 1'b0;
    send(32'h8000_7FFF, 2'b01, 4'b1010);
    chk("c4_in_ready_low", in_ready2, 0);
    operand   = 32'hDEAD_BEEF;
    precision = 2'b10;
    negate    = 4'b1000;
    in_valid  = 1'b1;
    repeat (3) step();
    chk("c4_stall_no_accept", acc2, 0);
    out_ready = 1'b1;
    send(32'hDEAD_BEEF, 2'b10, 4'b1000);
    send(32'h00FF_0080, 2'b00, 4'b1111);
    repeat (3) step();

    // Case 5: reset with two beats in flight
    out_ready = 1'b0;
    send(32'hAAAA_5555, 2'b01, 4'b1111);
    send(32'h0F0F_F0F0, 2'b00, 4'b0011);
    #2;
    rst = 1'b1;
    #1;
    chk("c5_async_valid2", out_valid2, 0);
    chk("c5_async_result2", result2, 0);
    chk("c5_async_valid1", out_valid1, 0);
    chk("c5_async_result1", result1, 0);
    q2.delete();
    q1.delete();
    hold2    = 1'b0;
    hold1    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    eg = model(32'h7654_3210, 2'b10, 4'b1000);
    send(32'h7654_3210, 2'b10, 4'b1000);
    chk("c5_post_valid2_early", out_valid2, 0);
    step();
    chk("c5_post_valid2", out_valid2, 1);
    chk("c5_post_result2", result2, eg[DW-1:0]);
    step();

    // Case 6: precision 11 as 32-bit, most negative value
    send(32'h8000_0000, 2'b11, 4'b1000);
    chk("c6_valid1", out_valid1, 1);
    chk("c6_result1", result1, 32'h8000_0000);
    chk("c6_ovf1", ovf1, OVF_EN ? 4'b1000 : 4'b0000);
    step();
    chk("c6_result2", result2, 32'h8000_0000);
    step();

    // Randomized traffic with random backpressure and boundary operands
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      precision = 2'($urandom_range(0, 3));
      negate    = 4'($urandom);
      case ($urandom_range(0, 7))
        0:       operand = 32'h0000_0000;
        1:       operand = 32'h8000_8000;
        2:       operand = 32'h8080_8080;
        3:       operand = 32'h8000_0000;
        default: operand = $urandom;
      endcase
      step();
    end

    // Drain both units and confirm nothing was lost
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q2.size() == 0 && q1.size() == 0) break;
      step();
    end
    chk("final_q2_empty", q2.size(), 0);
    chk("final_q1_empty", q1.size(), 0);
    step();
    chk("final_idle_valid2", out_valid2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
